// File: rtl/clap_round_ctrl_if.sv
// Handshake bundle between the round controller, the button/control logic,
// the beat counter and the score display.
interface clap_round_ctrl_if;
    logic        start;
    logic        abort;
    logic        clap;
    logic [16:0] ctr_count;
    logic        ctr_go;
    logic        ctr_en;
    logic        hit;
    logic        miss;
    logic [3:0]  beat_idx;
    logic [7:0]  score;
    logic [7:0]  misses;
    logic        busy;
    logic        done;

    modport master (
        output start, abort, clap, ctr_count,
        input  ctr_go, ctr_en, hit, miss, beat_idx, score, misses, busy, done
    );

    modport slave (
        input  start, abort, clap, ctr_count,
        output ctr_go, ctr_en, hit, miss, beat_idx, score, misses, busy, done
    );
endinterface

// File: rtl/clap_round_ctrl.sv
// Clap game round controller: runs NUM_BEATS beats of the external beat
// counter, grades one clap per beat against a window around TARGET and keeps
// saturating hit/miss tallies for the display.
module clap_round_ctrl #(
    parameter int unsigned NUM_BEATS = 8,
    parameter logic [16:0] BEAT_END  = 17'd66080,
    parameter logic [16:0] TARGET    = 17'd33040,
    parameter logic [16:0] WINDOW    = 17'd4000
) (
    input  logic              clk,
    input  logic              resetn,
    clap_round_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        COUNT = 3'd2,
        GRADE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [16:0] WIN_LO    = TARGET - WINDOW;
    localparam logic [16:0] WIN_HI    = TARGET + WINDOW;
    localparam logic [3:0]  LAST_BEAT = 4'(NUM_BEATS - 1);

    // Saturating tally increment: the display never wraps back to zero.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    state_t      state;
    state_t      next_state;

    logic        clap_p0;
    logic        clap_p1;
    logic        clap_p2;
    logic        clap_evt;

    logic        graded;
    logic        result;
    logic [7:0]  score_cnt;
    logic [7:0]  miss_cnt;
    logic [3:0]  beat_cnt;
    logic        hit_r;
    logic        miss_r;
    logic        done_r;

    logic        ctr_go;
    logic        ctr_en;
    logic        in_window;
    logic        beat_end;
    logic        take_clap;
    logic        final_hit;

    assign in_window = (bus.ctr_count >= WIN_LO) && (bus.ctr_count <= WIN_HI);
    assign beat_end  = (bus.ctr_count >= BEAT_END);
    assign take_clap = clap_evt && !graded;
    // A clap arriving on the end-of-beat cycle is still graded, against the
    // current (out-of-window) count.
    assign final_hit = graded ? result : (clap_evt && in_window);

    // Clap synchroniser (p0/p1) plus a registered rising-edge detect (p2).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clap_p0  <= 1'b0;
            clap_p1  <= 1'b0;
            clap_p2  <= 1'b0;
            clap_evt <= 1'b0;
        end else begin
            clap_p0  <= bus.clap;
            clap_p1  <= clap_p0;
            clap_p2  <= clap_p1;
            clap_evt <= clap_p1 && !clap_p2;
        end
    end

    // Next-state decode and counter strobes; abort overrides everything.
    always_comb begin
        next_state = state;
        ctr_go     = 1'b0;
        ctr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) next_state = ARM;
            end
            ARM: begin
                ctr_go     = 1'b1;
                next_state = COUNT;
            end
            COUNT: begin
                if (beat_end) next_state = GRADE;
                else          ctr_en     = 1'b1;
            end
            GRADE: begin
                next_state = (beat_cnt == LAST_BEAT) ? DONE : ARM;
            end
            DONE: begin
                if (bus.start) next_state = ARM;
            end
            default: next_state = IDLE;
        endcase
        if (bus.abort) next_state = IDLE;
    end

    // State register, grading, pulses and tallies.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            graded    <= 1'b0;
            result    <= 1'b0;
            score_cnt <= 8'd0;
            miss_cnt  <= 8'd0;
            beat_cnt  <= 4'd0;
            hit_r     <= 1'b0;
            miss_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state  <= next_state;
            hit_r  <= 1'b0;
            miss_r <= 1'b0;
            done_r <= (next_state == DONE);
            case (state)
                IDLE, DONE: begin
                    if (next_state == ARM) begin
                        score_cnt <= 8'd0;
                        miss_cnt  <= 8'd0;
                        beat_cnt  <= 4'd0;
                    end
                end
                ARM: begin
                    graded <= 1'b0;
                    result <= 1'b0;
                end
                COUNT: begin
                    if (next_state != IDLE) begin
                        if (take_clap) begin
                            graded <= 1'b1;
                            result <= in_window;
                        end
                        if (beat_end) begin
                            hit_r  <= final_hit;
                            miss_r <= !final_hit;
                        end
                    end
                end
                GRADE: begin
                    if (next_state != IDLE) begin
                        if (hit_r) score_cnt <= sat_inc(score_cnt);
                        else       miss_cnt  <= sat_inc(miss_cnt);
                        if (next_state == ARM) beat_cnt <= beat_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ctr_go   = ctr_go;
    assign bus.ctr_en   = ctr_en;
    assign bus.busy     = (state == ARM) || (state == COUNT) || (state == GRADE);
    assign bus.hit      = hit_r;
    assign bus.miss     = miss_r;
    assign bus.done     = done_r;
    assign bus.score    = score_cnt;
    assign bus.misses   = miss_cnt;
    assign bus.beat_idx = beat_cnt;

endmodule

// File: doc/clap_round_ctrl.md
Name: clap_round_ctrl

Overview:
Sequences the 17-bit clap beat counter through one game round of NUM_BEATS beats. For each beat it clears and runs the counter, then grades the player's clap against a timing window centred on TARGET. It also keeps hit/miss scoring. It sits between the button/control logic and the beat counter; its score outputs drive the HEX/LED display logic.

Parameters:
NUM_BEATS, 8, beats per round (1..15)
BEAT_END, 17'd66080, counter value that ends a beat
TARGET, 17'd33040, ideal clap count within a beat
WINDOW, 17'd4000, half-width of hit window; requires WINDOW <= TARGET and TARGET+WINDOW < BEAT_END

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  synchronous pulse/level; begins a round from IDLE or DONE
abort  in  1  synchronous; returns to IDLE from any state
clap  in  1  raw asynchronous clap button, active-high
ctr_count  in  17  current beat counter value
ctr_go  out  1  counter clear strobe (one cycle)
ctr_en  out  1  counter count enable
hit  out  1  one-cycle pulse: beat graded as hit
miss  out  1  one-cycle pulse: beat graded as miss
beat_idx  out  4  index of current beat, 0..NUM_BEATS-1
score  out  8  hits this round, saturating at 255
misses  out  8  misses this round, saturating at 255
busy  out  1  high in ARM/COUNT/GRADE
done  out  1  high in DONE

Behaviour:
- Reset (resetn=0, async): state=IDLE; every output 0; clap sync flops and graded flag cleared.
- clap passes through a 2-flop synchroniser, then a rising-edge detect (clap_evt). This gives 3 cycles from pin to clap_evt.
- IDLE: all strobes 0. On start, clear score, misses and beat_idx, then go to ARM.
- ARM (1 cycle): ctr_go=1, ctr_en=0, graded flag cleared. Go to COUNT. The counter reads 0 on the first COUNT cycle.
- COUNT: ctr_en=1.
  - If clap_evt and graded=0: set graded=1.
  - If TARGET-WINDOW <= ctr_count <= TARGET+WINDOW (inclusive, unsigned 17-bit compare), latch result=hit; otherwise latch result=miss.
  - Once graded=1, further clap_evt in the same beat are ignored.
  - If ctr_count >= BEAT_END, go to GRADE with ctr_en=0 that cycle. If graded=0 at that point, result=miss.
  - If clap_evt and end-of-beat occur in the same cycle, the clap is graded first, using the current ctr_count; it is a miss because the count is outside the window.
- GRADE (1 cycle): ctr_en=0.
  - Pulse hit or miss (exactly one).
  - Increment score or misses (saturating).
  - If beat_idx==NUM_BEATS-1, go to DONE with beat_idx held. Otherwise increment beat_idx and go to ARM.
- DONE: done=1. score, misses and beat_idx are held. start begins a new round (to ARM, counters cleared); clap is ignored.
- abort (any non-IDLE state): go to IDLE next cycle.
  - ctr_en and ctr_go drop to 0 and no hit/miss pulse is issued.
  - score and misses are held until the next start.
  - abort has priority over start and over grading in the same cycle.
- start in ARM, COUNT or GRADE is ignored.
- Beat latency: 1 (ARM) + BEAT_END+1 (COUNT) + 1 (GRADE) cycles per beat, independent of clap timing.
- Outputs are registered except ctr_go, ctr_en and busy, which decode directly from state.

Test Plan:
- Reset mid-COUNT (resetn low at beat 3) -> all outputs 0 immediately, state IDLE; a following start begins at beat_idx=0.
- NUM_BEATS=4, BEAT_END=100, TARGET=50, WINDOW=5; start, clap timed so clap_evt hits ctr_count=50 every beat -> 4 hit pulses, score=4, misses=0, done=1 after 4*(1+101+1) cycles.
- Same params, clap_evt at counts 45 and 55 (edges) then 44 and 56 -> hit, hit, miss, miss; score=2, misses=2.
- No clap for a full beat -> miss pulse in GRADE at ctr_count=100; double clap at 50 then 52 in one beat -> only one hit, score +1.
- abort asserted in COUNT of beat 2 with a simultaneous start -> IDLE next cycle, no pulse, score unchanged, ctr_en=0; start in DONE -> score/misses cleared, ARM entered with ctr_go=1.
- Saturation: force score=255 (NUM_BEATS=15, repeated rounds with preload via bench hierarchical deposit) -> further hit keeps score=255.
